adc_stat_accum: RTL and testbench
=================================

ADC_STAT_ACCUM -- requirements
Module: adc_stat_accum

Interface
REQ-001 Parameter N_ADC, default 8, signed ADC code width.
REQ-002 Parameter N_AVG_MAX, default 10, max log2 window length; sum width S = N_ADC+N_AVG_MAX, count width C = N_AVG_MAX+1.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rstb  input  1  asynchronous active-low reset.
REQ-005 en  input  1  run enable; low SHALL abort the window and hold outputs.
REQ-006 adc_valid  input  1  adc_code sample qualifier.
REQ-007 adc_code  input  N_ADC  signed ADC sample.
REQ-008 Navg_adc  input  4  log2 window length.
REQ-009 Nbin_adc  input  N_ADC  signed histogram centre code.
REQ-010 DZ_hist_adc  input  N_ADC  unsigned dead-zone half-width.
REQ-011 adcout_sum  output  S  signed window sum.
REQ-012 adcout_avg  output  N_ADC  signed window mean.
REQ-013 adcout_hist_center  output  C  count of centre hits.
REQ-014 adcout_hist_side  output  C  count of upper-side hits.
REQ-015 stat_update  output  1  one-cycle pulse on output refresh.

Function
REQ-016 Window length SHALL be W = 2^min(Navg_adc, N_AVG_MAX).
REQ-017 Navg_adc, Nbin_adc and DZ_hist_adc SHALL be captured at window start and held for the whole window.
REQ-018 States: IDLE, ACCUM, UPDATE.
REQ-019 IDLE -> ACCUM on the first cycle with en=1, capturing config and clearing accumulators and sample counter.
REQ-020 In ACCUM each cycle with adc_valid=1 SHALL add sign-extended adc_code to the S-bit sum and increment the sample counter; adc_valid=0 cycles SHALL be ignored.
REQ-021 Centre hit: Nbin-DZ <= adc_code <= Nbin+DZ, evaluated at N_ADC+2 bits signed with no wrap.
REQ-022 Side hit: adc_code > Nbin+DZ, same width rule; centre and side hits SHALL be mutually exclusive.
REQ-023 ACCUM -> UPDATE on the cycle the W-th valid sample is accepted; that sample SHALL be included.
REQ-024 In UPDATE, outputs SHALL load the final sum, counts and avg = sum arithmetically right-shifted by captured Navg (floor toward minus infinity), truncated to N_ADC bits; stat_update=1 that cycle only.
REQ-025 Latency: outputs and stat_update SHALL be valid the cycle after the W-th sample is accepted.
REQ-026 UPDATE -> ACCUM unconditionally with new config capture and cleared accumulators if en=1, else -> IDLE; adc_valid during UPDATE SHALL be discarded.
REQ-027 en=0 in ACCUM SHALL return to IDLE, discard the partial window, and leave outputs unchanged.
REQ-028 Outputs SHALL hold their last value between updates.
REQ-029 Navg_adc=0 SHALL give W=1, one update per accepted sample plus the UPDATE cycle.
REQ-030 Accumulators SHALL NOT overflow, since S and C bound W*max|code|.

Reset
REQ-031 rstb low SHALL force IDLE and zero sum, counts, sample counter, all outputs and stat_update, mid-window included.
REQ-032 Reset release SHALL be synchronised to clk before it leaves IDLE.

Structure
REQ-033 N_ADC and N_AVG_MAX defaults and the state enum SHALL live in the shared debug package.
REQ-034 One sub-module adc_hist_bin SHALL hold the centre/side compare and the two hit counters.
REQ-035 The outputs SHALL connect unchanged to the same-named fields of the digital debug interface feeding the JTAG register file.

Verification
REQ-036 Navg=2, codes 10,20,30,-4 consecutive -> sum=56, avg=14, stat_update one cycle after the 4th sample.
REQ-037 Navg=3, Nbin=0, DZ=2, codes -3,-2,0,2,3,5,-10,1 -> center=4, side=2, sum=-4, avg=-1.
REQ-038 Navg=10, all codes -128 -> sum=-131072, avg=-128, no overflow.
REQ-039 Navg=2 with adc_valid gaps, Navg changed to 4 mid-window -> window closes after 4 valid samples, next window uses 16.
REQ-040 rstb pulsed low after 3 of 8 samples -> all outputs 0 immediately; after release a full fresh window is needed before stat_update.
REQ-041 en dropped mid-window -> outputs keep previous window values, no stat_update, restart on en=1.

Source files
------------

// File: rtl/adc_stat_accum_pkg.sv
// Shared definitions for the ADC statistics accumulator: parameter defaults and FSM states.
package adc_stat_accum_pkg;

  localparam int unsigned NAdcDefault    = 8;
  localparam int unsigned NAvgMaxDefault = 10;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StUpdate
  } state_e;

endpackage

// File: rtl/adc_hist_bin.sv
// Centre/side histogram bin: classifies each accepted code against the captured
// window [nbin-dz, nbin+dz] and counts centre and upper-side hits.
module adc_hist_bin
  import adc_stat_accum_pkg::*;
#(
  parameter int unsigned N_ADC = NAdcDefault,
  parameter int unsigned C     = NAvgMaxDefault + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             acc,
  input  logic [N_ADC-1:0] code,
  input  logic [N_ADC-1:0] nbin,
  input  logic [N_ADC-1:0] dz,
  output logic [C-1:0]     center_next,
  output logic [C-1:0]     side_next
);

  // Two extra bits so nbin +/- dz can never wrap.
  localparam int unsigned X = N_ADC + 2;

  logic signed [X-1:0] code_x, lo_x, hi_x;
  logic                center_hit, side_hit;
  logic [C-1:0]        center_q, side_q;

  // Classify the current code; centre and side are exclusive by construction.
  always_comb begin
    code_x     = {{2{code[N_ADC-1]}}, code};
    lo_x       = {{2{nbin[N_ADC-1]}}, nbin} - {2'b00, dz};
    hi_x       = {{2{nbin[N_ADC-1]}}, nbin} + {2'b00, dz};
    center_hit = (code_x >= lo_x) && (code_x <= hi_x);
    side_hit   = (code_x > hi_x);
  end

  // Next counter values, exposed so the top can latch the count including the last sample.
  always_comb begin
    center_next = center_q;
    side_next   = side_q;
    if (clr) begin
      center_next = '0;
      side_next   = '0;
    end else if (acc) begin
      center_next = center_q + {{(C-1){1'b0}}, center_hit};
      side_next   = side_q + {{(C-1){1'b0}}, side_hit};
    end
  end

  // Hit counter registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      center_q <= '0;
      side_q   <= '0;
    end else begin
      center_q <= center_next;
      side_q   <= side_next;
    end
  end

endmodule

// File: rtl/adc_stat_accum.sv
// Windowed ADC statistics: sum, mean and centre/side histogram over 2^Navg valid samples.
module adc_stat_accum
  import adc_stat_accum_pkg::*;
#(
  parameter int unsigned N_ADC     = NAdcDefault,
  parameter int unsigned N_AVG_MAX = NAvgMaxDefault
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  input  logic                     adc_valid,
  input  logic [N_ADC-1:0]         adc_code,
  input  logic [3:0]               Navg_adc,
  input  logic [N_ADC-1:0]         Nbin_adc,
  input  logic [N_ADC-1:0]         DZ_hist_adc,
  output logic [N_ADC+N_AVG_MAX-1:0] adcout_sum,
  output logic [N_ADC-1:0]         adcout_avg,
  output logic [N_AVG_MAX:0]       adcout_hist_center,
  output logic [N_AVG_MAX:0]       adcout_hist_side,
  output logic                     stat_update
);

  localparam int unsigned S = N_ADC + N_AVG_MAX;
  localparam int unsigned C = N_AVG_MAX + 1;
  localparam logic [3:0] NavgLimit = (N_AVG_MAX > 15) ? 4'd15 : 4'(N_AVG_MAX);

  state_e state_q, state_d;

  logic [1:0]             rst_sync_q;
  logic                   rst_done;
  logic                   start, accept, close;
  logic [3:0]             navg_q, navg_clamp;
  logic [N_ADC-1:0]       nbin_q, dz_q;
  logic [C-1:0]           cnt_q, cnt_d, win_len;
  logic signed [S-1:0]    sum_q, sum_d, code_sx;
  logic [C-1:0]           center_next, side_next;
  logic [S-1:0]           sum_out_q;
  logic [N_ADC-1:0]       avg_out_q;
  logic [C-1:0]           center_out_q, side_out_q;

  // Reset release is synchronised before the FSM may leave idle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_done = rst_sync_q[1];

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en && rst_done) state_d = StAccum;
      StAccum: begin
        if (!en)       state_d = StIdle;
        else if (close) state_d = StUpdate;
      end
      StUpdate: state_d = en ? StAccum : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: window start, sample acceptance and window close.
  always_comb begin
    start       = ((state_q == StIdle) && en && rst_done) || ((state_q == StUpdate) && en);
    accept      = (state_q == StAccum) && en && adc_valid;
    close       = accept && ((cnt_q + {{(C-1){1'b0}}, 1'b1}) == win_len);
    stat_update = (state_q == StUpdate);
  end

  // Window datapath next state: clamp config, window length, running sum and count.
  always_comb begin
    navg_clamp = (Navg_adc > NavgLimit) ? NavgLimit : Navg_adc;
    win_len    = {{(C-1){1'b0}}, 1'b1} << navg_q;
    code_sx    = {{N_AVG_MAX{adc_code[N_ADC-1]}}, adc_code};
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    if (start) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = sum_q + code_sx;
      cnt_d = cnt_q + {{(C-1){1'b0}}, 1'b1};
    end
  end

  // Config capture and accumulator registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      navg_q <= '0;
      nbin_q <= '0;
      dz_q   <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (start) begin
        navg_q <= navg_clamp;
        nbin_q <= Nbin_adc;
        dz_q   <= DZ_hist_adc;
      end
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  adc_hist_bin #(
    .N_ADC (N_ADC),
    .C     (C)
  ) u_hist (
    .clk         (clk),
    .rstb        (rstb),
    .clr         (start),
    .acc         (accept),
    .code        (adc_code),
    .nbin        (nbin_q),
    .dz          (dz_q),
    .center_next (center_next),
    .side_next   (side_next)
  );

  // Outputs load on the closing edge so they are valid during the update cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sum_out_q    <= '0;
      avg_out_q    <= '0;
      center_out_q <= '0;
      side_out_q   <= '0;
    end else if (close) begin
      sum_out_q    <= sum_d;
      avg_out_q    <= N_ADC'(sum_d >>> navg_q);
      center_out_q <= center_next;
      side_out_q   <= side_next;
    end
  end

  assign adcout_sum         = sum_out_q;
  assign adcout_avg         = avg_out_q;
  assign adcout_hist_center = center_out_q;
  assign adcout_hist_side   = side_out_q;

endmodule

// File: tb/tb_adc_stat_accum.sv
// Directed bench for adc_stat_accum with hand-computed window results.
module tb_adc_stat_accum;

  logic        clk = 1'b0;
  logic        rstb, en, adc_valid;
  logic [7:0]  adc_code, Nbin_adc, DZ_hist_adc;
  logic [3:0]  Navg_adc;
  logic [17:0] adcout_sum;
  logic [7:0]  adcout_avg;
  logic [10:0] adcout_hist_center, adcout_hist_side;
  logic        stat_update;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_stat_accum #(
    .N_ADC     (8),
    .N_AVG_MAX (10)
  ) dut (
    .clk                (clk),
    .rstb               (rstb),
    .en                 (en),
    .adc_valid          (adc_valid),
    .adc_code           (adc_code),
    .Navg_adc           (Navg_adc),
    .Nbin_adc           (Nbin_adc),
    .DZ_hist_adc        (DZ_hist_adc),
    .adcout_sum         (adcout_sum),
    .adcout_avg         (adcout_avg),
    .adcout_hist_center (adcout_hist_center),
    .adcout_hist_side   (adcout_hist_side),
    .stat_update        (stat_update)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input longint s, input longint a,
                               input longint c, input longint sd);
    check({tag, "_sum"}, longint'($signed(adcout_sum)), s);
    check({tag, "_avg"}, longint'($signed(adcout_avg)), a);
    check({tag, "_center"}, longint'(adcout_hist_center), c);
    check({tag, "_side"}, longint'(adcout_hist_side), sd);
  endtask

  // Drive one valid sample; also confirms no update is pending before it.
  task automatic send(input int code);
    @(negedge clk);
    check("no_early_update", longint'(stat_update), 0);
    adc_valid = 1'b1;
    adc_code  = 8'(code);
  endtask

  task automatic gap();
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  // Pass through idle for one cycle, then start a window with fresh config.
  task automatic start_window(input int navg, input int nbin, input int dz);
    @(negedge clk);
    en        = 1'b0;
    adc_valid = 1'b0;
    @(negedge clk);
    Navg_adc    = 4'(navg);
    Nbin_adc    = 8'(nbin);
    DZ_hist_adc = 8'(dz);
    en          = 1'b1;
  endtask

  // The cycle after the last sample: pulse high and outputs loaded.
  task automatic expect_update(input string tag, input longint s, input longint a,
                               input longint c, input longint sd);
    @(negedge clk);
    check({tag, "_pulse"}, longint'(stat_update), 1);
    check_outputs(tag, s, a, c, sd);
    adc_valid = 1'b0;
  endtask

  initial begin
    rstb = 1'b1; en = 1'b0; adc_valid = 1'b0; adc_code = '0;
    Navg_adc = '0; Nbin_adc = '0; DZ_hist_adc = '0;
    #3 rstb = 1'b0;
    #1;
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_pulse", longint'(stat_update), 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);

    // Basic mean over 4 samples.
    start_window(2, 0, 0);
    send(10); send(20); send(30); send(-4);
    expect_update("w4", 56, 14, 0, 3);
    @(negedge clk);
    check("w4_pulse_one_cycle", longint'(stat_update), 0);
    check("w4_hold_sum", longint'($signed(adcout_sum)), 56);

    // W=1: update per sample, sample during update discarded.
    start_window(0, 0, 0);
    send(7);
    expect_update("w1a", 7, 7, 0, 1);
    adc_valid = 1'b1;
    adc_code  = 8'(-5);
    @(negedge clk);
    check("w1_update_drop", longint'(stat_update), 0);
    check("w1_hold_sum", longint'($signed(adcout_sum)), 7);
    expect_update("w1b", -5, -5, 0, 0);

    // Histogram with dead zone, negative floor mean.
    start_window(3, 0, 2);
    send(-3); send(-2); send(0); send(2); send(3); send(5); send(-10); send(1);
    expect_update("hist", -4, -1, 4, 2);

    // Largest window at the most negative code.
    start_window(10, -128, 0);
    for (int i = 0; i < 1024; i++) send(-128);
    expect_update("w1024", -131072, -128, 1024, 0);

    // Valid gaps and a config change mid-window; next window uses the new length.
    start_window(2, 0, 0);
    send(1); gap(); send(2); gap();
    @(negedge clk);
    adc_valid = 1'b0;
    Navg_adc  = 4'd4;
    send(3); send(4);
    expect_update("gaps", 10, 2, 0, 4);
    adc_valid = 1'b1;
    adc_code  = 8'd100;
    for (int i = 0; i < 16; i++) send(1);
    expect_update("w16", 16, 1, 0, 16);

    // Reset mid-window clears everything; a full fresh window is needed afterwards.
    start_window(3, 0, 0);
    send(50); send(50); send(50);
    @(negedge clk);
    rstb = 1'b0; en = 1'b0; adc_valid = 1'b0;
    #1;
    check_outputs("midrst", 0, 0, 0, 0);
    check("midrst_pulse", longint'(stat_update), 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    start_window(3, 0, 0);
    for (int i = 1; i <= 8; i++) send(i);
    expect_update("fresh", 36, 4, 0, 8);

    // Dropping en aborts the window and holds outputs.
    send(9); send(9); send(9); send(9);
    @(negedge clk);
    en = 1'b0; adc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_pulse", longint'(stat_update), 0);
      check("abort_hold_sum", longint'($signed(adcout_sum)), 36);
    end
    check_outputs("abort_hold", 36, 4, 0, 8);
    start_window(3, 0, 0);
    for (int i = 0; i < 8; i++) send(-1);
    expect_update("restart", -8, -1, 0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
